port_arbiter: RTL
=================

// Module: port_arbiter
// PURPOSE
//  Round-robin, packet-granular arbiter sharing one router output data port between two input ports.
//  Sits between the two input-port buffers and the output data register stage.
//  Grants one requester at a time and holds the grant until that packet ends.
//  Steers the granted port's data/valid/last to the output and returns ready only to the granted port.
// PARAMETERS
//  size      8    data width in bits
//  MAX_BEATS 16   max beats per grant; forced release after this many accepted beats (>=1)
//  TIMEOUT   64   idle cycles under grant before forced release (ARB_TIMEOUT_EN only, >=1)
// PORTS
//  clock      in   1     rising-edge clock
//  reset      in   1     synchronous, active-high reset
//  port1Req   in   1     port 1 has a packet pending
//  port1Valid in   1     port 1 beat valid
//  port1Last  in   1     port 1 beat is last of packet
//  port1Data  in   size  port 1 beat data
//  port1Ready out  1     port 1 beat accepted this cycle
//  port2Req / port2Valid / port2Last / port2Data / port2Ready   as port 1, for port 2
//  outReady   in   1     downstream accepts a beat
//  outValid   out  1     output beat valid
//  outLast    out  1     output beat is last
//  outData    out  size  output beat data
//  grant      out  2     one-hot current grant {port2,port1}; 2'b00 = idle
// BEHAVIOUR
//  - FSM states: IDLE, GNT1, GNT2. State, RR pointer and beat counter are registered; steering is combinational from state.
//  - Reset: state=IDLE, RR pointer favours port 1, beat count=0; grant=0, outValid=0, outLast=0, outData=0, port1Ready=port2Ready=0.
//  - IDLE: if only one req, go to that GNTx next cycle. If both req, grant the port the pointer favours.
//  - Grant latency: 1 cycle from req to grant. No data passes while in IDLE.
//  - GNTx: outData/outValid/outLast = portx signals; portxReady = outReady; the other port's ready = 0.
//  - A beat is accepted when portxValid & outReady. Each accepted beat increments the beat count.
//  - Release condition: an accepted beat with portxLast=1, or the accepted beat that brings the count to MAX_BEATS.
//    On release: count cleared, pointer moves to the other port.
//  - Next state after release: if the other port's req is high, go directly to the other GNT (no IDLE bubble).
//    Otherwise, if own req is still high, stay in own GNT. Otherwise go to IDLE.
//  - Dropping portxReq under grant with no beat in flight: return to IDLE next cycle; pointer moves.
//  - Outputs when not granted: outValid=0, outLast=0, outData=0 (no stale data).
//  - Beat count is clog2(MAX_BEATS+1) bits wide and saturates; it never wraps.
//  - A synchronous reset mid-packet aborts the grant immediately. The upstream buffer must tolerate the lost tail.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - An idle counter increments each GNTx cycle with no accepted beat, and clears on any accepted beat.
//   - Reaching TIMEOUT forces a release exactly as a last beat does (pointer moves, count cleared).
//  ARB_TIMEOUT_EN undefined: no idle counter; a granted stalled port holds the output indefinitely.
// STRUCTURE
//  - Shared package router_pkg holds:
//    - arb_state_t enum (IDLE=2'd0, GNT1=2'd1, GNT2=2'd2)
//    - GRANT_NONE/GRANT_P1/GRANT_P2 one-hot constants
//    - default MAX_BEATS/TIMEOUT
//  - One natural sub-module, arb_beat_counter: saturating counter with clear/inc/limit-hit, reused for the timeout counter.
//  - FSM and steering mux stay in port_arbiter.
// TESTING
//  1. Reset: hold reset 3 cycles with both req=1 -> grant=00, outValid=0, both readys=0; first grant=01 one cycle after release.
//  2. Contention: both req, 3-beat packets (0xA1,0xA2,0xA3 last / 0xB1,0xB2,0xB3 last), outReady=1 ->
//     output A1 A2 A3 B1 B2 B3 with no gap; grant goes 01 then 10.
//  3. Backpressure: outReady toggled 1,0,1,0 under GNT1 -> port1Ready mirrors outReady; port2Ready stays 0; no beat duplicated or dropped.
//  4. MAX_BEATS=4: port 1 sends 6 beats with no last while port 2 requests -> grant moves to 10 after beat 4.
//     Port 1 is regranted after port 2's packet.
//  5. Mid-packet reset: assert reset after beat 2 of 3 -> next cycle grant=00, outValid=0, pointer favours port 1.
//  6. ARB_TIMEOUT_EN, TIMEOUT=8: port 1 granted, valid held 0 for 8 cycles with port 2 requesting -> grant=10 the cycle after the 8th idle cycle.
//     Without the macro, grant stays 01.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions used by the output-port arbiter.
//   arb_state_t          : arbiter FSM state encoding (IDLE / GNT1 / GNT2)
//   GRANT_NONE/P1/P2     : one-hot grant vectors {port2,port1}
//   DEFAULT_MAX_BEATS    : default beat limit per grant
//   DEFAULT_TIMEOUT      : default idle-cycle limit under grant (ARB_TIMEOUT_EN builds)
package router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P1   = 2'b01;
    localparam logic [1:0] GRANT_P2   = 2'b10;

    localparam int DEFAULT_MAX_BEATS = 16;
    localparam int DEFAULT_TIMEOUT   = 64;

endpackage

// File: rtl/arb_beat_counter.sv
// Saturating event counter with a look-ahead limit flag.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  synchronous active-high reset (count -> 0)
//   clear  in  synchronous clear, takes priority over inc
//   inc    in  count one event this cycle
//   hit    out this cycle's inc brings the count to LIMIT
// The count is clog2(LIMIT+1) bits and holds at LIMIT rather than wrapping.
module arb_beat_counter #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic hit
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX_COUNT  = W'(LIMIT);
    localparam logic [W-1:0] LAST_COUNT = W'(LIMIT - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg < MAX_COUNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Flag the event that completes the limit, so the owner can act on the
    // same edge the final event is taken.
    assign hit = inc && (count_reg >= LAST_COUNT);

endmodule

// File: rtl/port_arbiter.sv
// Round-robin, packet-granular arbiter sharing one output data port between
// two input ports. A grant is held until the packet's last beat, MAX_BEATS
// accepted beats, the owner dropping its request, or (ARB_TIMEOUT_EN builds)
// TIMEOUT cycles under grant without an accepted beat.
// Optional feature macro: ARB_TIMEOUT_EN (idle timeout release).
// Ports:
//   clock, reset                   clock and synchronous active-high reset
//   portNReq/Valid/Last/Data       input port N request and beat (N = 1, 2)
//   portNReady                     input port N beat accepted this cycle
//   outReady                       downstream accepts a beat
//   outValid/outLast/outData       steered output beat (zero when idle)
//   grant                          one-hot grant {port2,port1}, 00 = idle
module port_arbiter
    import router_pkg::*;
#(
    parameter int size      = 8,
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            port1Req,
    input  logic            port1Valid,
    input  logic            port1Last,
    input  logic [size-1:0] port1Data,
    output logic            port1Ready,
    input  logic            port2Req,
    input  logic            port2Valid,
    input  logic            port2Last,
    input  logic [size-1:0] port2Data,
    output logic            port2Ready,
    input  logic            outReady,
    output logic            outValid,
    output logic            outLast,
    output logic [size-1:0] outData,
    output logic [1:0]      grant
);

    // Elaboration-time parameter sanity.
    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("port_arbiter: MAX_BEATS must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("port_arbiter: TIMEOUT must be >= 1");
    end

    arb_state_t state_reg, state_next;
    // 0: port 1 wins the next contended grant, 1: port 2 wins.
    logic ptr_reg, ptr_next;

    logic granted;
    logic own_req;
    logic accept;
    logic beat_hit;
    logic timeout_hit;
    logic rel;
    logic drop;

    // Steering is a pure decode of the registered state, so the output
    // reflects the owner's beat in the same cycle it is presented.
    always_comb begin
        outValid   = 1'b0;
        outLast    = 1'b0;
        outData    = '0;
        port1Ready = 1'b0;
        port2Ready = 1'b0;
        grant      = GRANT_NONE;
        own_req    = 1'b0;
        case (state_reg)
            GNT1: begin
                outValid   = port1Valid;
                outLast    = port1Last;
                outData    = port1Data;
                port1Ready = outReady;
                grant      = GRANT_P1;
                own_req    = port1Req;
            end
            GNT2: begin
                outValid   = port2Valid;
                outLast    = port2Last;
                outData    = port2Data;
                port2Ready = outReady;
                grant      = GRANT_P2;
                own_req    = port2Req;
            end
            default: ;
        endcase
    end

    assign granted = (state_reg == GNT1) || (state_reg == GNT2);
    assign accept  = outValid && outReady;

    // Beat count for the current grant; cleared on any grant end.
    arb_beat_counter #(
        .LIMIT (MAX_BEATS)
    ) u_beat_count (
        .clock (clock),
        .reset (reset),
        .clear (rel || drop || !granted),
        .inc   (accept),
        .hit   (beat_hit)
    );

`ifdef ARB_TIMEOUT_EN
    // Idle cycles under grant; any accepted beat restarts the window.
    arb_beat_counter #(
        .LIMIT (TIMEOUT)
    ) u_idle_count (
        .clock (clock),
        .reset (reset),
        .clear (!granted || accept || timeout_hit),
        .inc   (granted && !accept),
        .hit   (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign rel  = (accept && (outLast || beat_hit)) || timeout_hit;
    // Requester withdrew with nothing moving: give the port back.
    assign drop = granted && !own_req && !accept && !rel;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (port1Req && port2Req) begin
                    state_next = ptr_reg ? GNT2 : GNT1;
                end else if (port1Req) begin
                    state_next = GNT1;
                end else if (port2Req) begin
                    state_next = GNT2;
                end
            end
            GNT1: begin
                if (rel) begin
                    ptr_next = 1'b1;
                    // Hand over directly when the other port is waiting.
                    if (port2Req) begin
                        state_next = GNT2;
                    end else if (port1Req) begin
                        state_next = GNT1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (drop) begin
                    ptr_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            GNT2: begin
                if (rel) begin
                    ptr_next = 1'b0;
                    if (port1Req) begin
                        state_next = GNT1;
                    end else if (port2Req) begin
                        state_next = GNT2;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (drop) begin
                    ptr_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset aborts any grant in progress; the upstream buffer discards
    // whatever tail of the packet was not accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

endmodule
